store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered stores (power of two, 2..16).
REQ-002 Parameter: W, 32, address and data width.
REQ-003 The module SHALL have one clock, clk; reset is asynchronous and active-low, named reset.
REQ-004 Ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  memwrite  in  1  store request from pipeline memory stage
  memread  in  1  load lookup request from pipeline memory stage
  dataadr  in  W  byte address of store/load
  writedata  in  W  store data
  stall  out  1  store not accepted this cycle
  ld_hit  out  1  load address matches a buffered store
  ld_data  out  W  forwarded data (youngest match)
  mem_we  out  1  write request to data memory
  mem_adr  out  W  head-entry address
  mem_wdata  out  W  head-entry data
  mem_ack  in  1  data memory accepts head write this cycle
  count  out  clog2(DEPTH)+1  occupied entries
  empty  out  1  count==0

Function
REQ-005 The buffer SHALL be a circular FIFO of {address, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-006 Enqueue SHALL occur at the clk edge when memwrite=1 and count<DEPTH.
REQ-007 stall SHALL equal memwrite & (count==DEPTH), combinationally; a stalled store is not captured and must be held by the core.
REQ-008 Full buffer with mem_ack=1 SHALL dequeue only; stall stays 1 that cycle, and the store enters the following cycle (no same-cycle bypass).
REQ-009 mem_we SHALL equal !empty; mem_adr/mem_wdata SHALL present the head entry combinationally.
REQ-010 Dequeue SHALL occur at the clk edge when mem_we & mem_ack; mem_ack while empty SHALL be ignored.
REQ-011 Simultaneous enqueue and dequeue with 0<count<DEPTH SHALL leave count unchanged and preserve order.
REQ-012 Enqueue into an empty buffer SHALL make mem_we=1 on the next cycle (one-cycle latency, no flow-through).
REQ-013 Load forwarding SHALL compare dataadr[W-1:2] against every valid entry; dataadr[1:0] ignored.
REQ-014 ld_hit SHALL be memread & (any match); ld_data SHALL be the youngest matching entry, zero when ld_hit=0.
REQ-015 The entry being dequeued in the current cycle SHALL still be searched for forwarding that cycle.
REQ-016 memwrite and memread both high SHALL be treated as a store only; ld_hit=0.
REQ-017 count SHALL be registered and range 0..DEPTH; empty SHALL be derived from count.

Reset
REQ-018 reset=0 SHALL asynchronously clear head, tail and count to 0 and invalidate all entries.
REQ-019 During and after reset: stall=0 unless memwrite=1 (count 0 so stall=0), mem_we=0, ld_hit=0, ld_data=0, empty=1, count=0.
REQ-020 Reset mid-drain SHALL discard all pending stores; no mem_we after reset release until a new enqueue.
REQ-021 Entry payload storage need not be reset; only validity matters.

Structure
REQ-022 DEPTH and W defaults and the entry-width constant SHALL reside in the shared mips package used by mipspipeline.
REQ-023 Forwarding match/priority logic SHALL be one sub-module, store_buffer_fwd, purely combinational, fed by entry arrays, valid vector and tail pointer.
REQ-024 Pointer/count control and storage SHALL stay in store_buffer.

Verification
REQ-025 Single store: memwrite, dataadr=84, writedata=7, mem_ack=1 -> next cycle mem_we=1, mem_adr=84, mem_wdata=7; following cycle empty=1.
REQ-026 Fill: 5 back-to-back stores to 0,4,8,12,16, mem_ack=0 -> count=4, 5th store sees stall=1; raise mem_ack -> drain order 0,4,8,12, then 16.
REQ-027 Forwarding: stores (80,5),(84,7),(80,9) buffered; memread dataadr=82 -> ld_hit=1, ld_data=9; dataadr=88 -> ld_hit=0, ld_data=0.
REQ-028 Simultaneous: count=2, memwrite and mem_ack same cycle -> count stays 2, FIFO order preserved across pointer wrap over 10 cycles.
REQ-029 Reset mid-drain: count=3, assert reset=0 between edges -> count=0, mem_we=0 immediately; release -> idle until next memwrite.
REQ-030 Boundary: mem_ack=1 while empty -> no pointer change; full plus mem_ack with memwrite -> stall=1, count goes 4->3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the mips pipeline and its store buffer.
//   SB_DEPTH   : default number of buffered stores
//   SB_W       : default address/data width
//   SB_ENTRY_W : width of one buffered {address, data} entry
package mips_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_W     = 32;

  // One entry holds a full byte address and the store data side by side.
  function automatic int sb_entry_w(input int w);
    return 2 * w;
  endfunction

  localparam int SB_ENTRY_W = sb_entry_w(SB_W);

endpackage

// File: rtl/store_buffer_fwd.sv
// Load-forwarding search over the store buffer entries (purely combinational).
// Ports:
//   tag_i      : word address (byte address bits [W-1:2]) of every entry
//   data_i     : store data of every entry
//   valid_i    : per-entry valid flags
//   tail_i     : next write slot; the youngest entry sits just below it
//   ld_tag_i   : word address of the load being looked up
//   memread_i  : load lookup request
//   memwrite_i : store request (a store wins over a load in the same cycle)
//   ld_hit_o   : a valid entry matches the load
//   ld_data_o  : data of the youngest matching entry, zero on a miss
module store_buffer_fwd
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int W     = SB_W,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][W-3:0] tag_i,
  input  logic [DEPTH-1:0][W-1:0] data_i,
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [PW-1:0]           tail_i,
  input  logic [W-3:0]            ld_tag_i,
  input  logic                    memread_i,
  input  logic                    memwrite_i,
  output logic                    ld_hit_o,
  output logic [W-1:0]            ld_data_o
);

  logic          match_s;
  logic [W-1:0]  match_data_s;
  logic [PW-1:0] idx_s;

  // Walk from the youngest entry (tail-1) towards the oldest; first hit wins.
  always_comb begin
    match_s      = 1'b0;
    match_data_s = {W{1'b0}};
    idx_s        = {PW{1'b0}};
    for (int k = 1; k <= DEPTH; k++) begin
      // Modulo-DEPTH wrap comes for free from the PW-bit subtraction.
      idx_s = tail_i - PW'(k);
      if (!match_s && valid_i[idx_s] && (tag_i[idx_s] == ld_tag_i)) begin
        match_s      = 1'b1;
        match_data_s = data_i[idx_s];
      end else begin
        match_s      = match_s;
      end
    end
  end

  // A simultaneous store takes priority, so the load lookup is suppressed.
  always_comb begin
    ld_hit_o  = match_s & memread_i & ~memwrite_i;
    if (ld_hit_o) begin
      ld_data_o = match_data_s;
    end else begin
      ld_data_o = {W{1'b0}};
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO store buffer between the pipeline memory stage and data memory.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   memwrite/dataadr/     : store request with byte address and data
//   writedata
//   stall                 : store refused this cycle (buffer full)
//   memread               : load lookup request, address on dataadr
//   ld_hit/ld_data        : load forwarding result (youngest matching store)
//   mem_we/mem_adr/       : head entry offered to data memory
//   mem_wdata
//   mem_ack               : data memory takes the head entry this cycle
//   count/empty           : occupancy
module store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int W     = SB_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic                     memread,
  input  logic [W-1:0]             dataadr,
  input  logic [W-1:0]             writedata,
  output logic                     stall,
  output logic                     ld_hit,
  output logic [W-1:0]             ld_data,
  output logic                     mem_we,
  output logic [W-1:0]             mem_adr,
  output logic [W-1:0]             mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam int            ENTRY_W  = sb_entry_w(W);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry layout: {address, data}. Payload is never reset; valid_q guards it.
  logic [DEPTH-1:0][ENTRY_W-1:0] entry_q;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [PW-1:0]                 head_q, head_d;
  logic [PW-1:0]                 tail_q, tail_d;
  logic [CW-1:0]                 count_q, count_d;

  logic                          full_s;
  logic                          enq_s;
  logic                          deq_s;
  logic [DEPTH-1:0][W-3:0]       tag_s;
  logic [DEPTH-1:0][W-1:0]       data_s;

  // Pointer, valid and occupancy next-state.
  always_comb begin
    full_s  = (count_q == FULL_CNT);
    // A full buffer never takes the store, even if the head drains this cycle.
    enq_s   = memwrite & ~full_s;
    // mem_ack against an empty buffer is ignored.
    deq_s   = (count_q != {CW{1'b0}}) & mem_ack;
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q;

    if (deq_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end else begin
      head_d          = head_q;
    end

    // With 0<count<DEPTH head and tail differ, so set/clear never collide.
    if (enq_s) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end else begin
      tail_d          = tail_q;
    end

    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      valid_q <= {DEPTH{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload capture at the tail slot.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      entry_q[tail_q] <= {dataadr, writedata};
    end
  end

  // Split entries into word tags and data for the forwarding search.
  always_comb begin
    tag_s  = '0;
    data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tag_s[i]  = entry_q[i][ENTRY_W-1:W+2];
      data_s[i] = entry_q[i][W-1:0];
    end
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .W     (W),
    .PW    (PW)
  ) u_fwd (
    .tag_i      (tag_s),
    .data_i     (data_s),
    .valid_i    (valid_q),
    .tail_i     (tail_q),
    .ld_tag_i   (dataadr[W-1:2]),
    .memread_i  (memread),
    .memwrite_i (memwrite),
    .ld_hit_o   (ld_hit),
    .ld_data_o  (ld_data)
  );

  // Memory-side and status outputs; the head entry is shown directly.
  always_comb begin
    stall     = memwrite & full_s;
    empty     = (count_q == {CW{1'b0}});
    mem_we    = ~empty;
    mem_adr   = entry_q[head_q][ENTRY_W-1:W];
    mem_wdata = entry_q[head_q][W-1:0];
    count     = count_q;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic, all checked against a queue-based model of the buffer.
module tb_store_buffer;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite, memread, mem_ack;
  logic [W-1:0]  dataadr, writedata;
  logic          stall, ld_hit, mem_we, empty;
  logic [W-1:0]  ld_data, mem_adr, mem_wdata;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: oldest store at index 0, entries packed {address, data}.
  logic [SB_ENTRY_W-1:0] q[$];

  store_buffer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .dataadr(dataadr), .writedata(writedata), .stall(stall), .ld_hit(ld_hit),
    .ld_data(ld_data), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent_adr(input logic [SB_ENTRY_W-1:0] e);
    return e[SB_ENTRY_W-1:W];
  endfunction

  function automatic logic [W-1:0] ent_dat(input logic [SB_ENTRY_W-1:0] e);
    return e[W-1:0];
  endfunction

  // Youngest buffered store to the same word, if any.
  function automatic bit m_hit(input logic [W-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (ent_adr(q[i]) >> 2 == a >> 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_data(input logic [W-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (ent_adr(q[i]) >> 2 == a >> 2) return ent_dat(q[i]);
    return '0;
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit e, d;
    @(posedge clk);
    if (reset) begin
      e = memwrite && (q.size() < DEPTH);
      d = (q.size() > 0) && mem_ack;
      if (d) void'(q.pop_front());
      if (e) q.push_back({dataadr, writedata});
    end
    #1;
  endtask

  task automatic idle();
    memwrite = 1'b0; memread = 1'b0; mem_ack = 1'b0;
    dataadr = '0; writedata = '0;
  endtask

  task automatic drain();
    idle();
    mem_ack = 1'b1;
    repeat (DEPTH + 1) tick();
    mem_ack = 1'b0;
  endtask

  task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    memwrite = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
    memwrite = 1'b0; memread = 1'b1;
    repeat (2) tick();
    n_cmp++; if (ld_hit !== 1'b0 || ld_data !== '0) begin n_bad++; $display("FAIL reset_ld: got hit=%0b data=%0h want 0/0", ld_hit, ld_data); end
    q.delete();
    reset = 1'b1;
    idle();
    tick();
    n_cmp++; if (mem_we !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL reset_release: got we=%0b count=%0d want 0/0", mem_we, count); end
  endtask

  task automatic test_single();
    idle();
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7; mem_ack = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL single_no_flowthrough: got %0b want 0", mem_we); end
    tick();
    memwrite = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL single_mem_we: got %0b want 1", mem_we); end
    n_cmp++; if (mem_adr !== 32'd84 || mem_wdata !== 32'd7) begin n_bad++; $display("FAIL single_head: got %0d/%0d want 84/7", mem_adr, mem_wdata); end
    tick();
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty: got %0b want 1", empty); end
    idle();
  endtask

  task automatic test_fill();
    logic [W-1:0] got[$];
    logic [W-1:0] want[5];
    want[0] = 32'd0; want[1] = 32'd4; want[2] = 32'd8; want[3] = 32'd12; want[4] = 32'd16;
    idle();
    for (int i = 0; i < 4; i++) begin
      memwrite = 1'b1; dataadr = W'(i * 4); writedata = W'(100 + i);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fill_stall_%0d: got %0b want 0", i, stall); end
      tick();
    end
    dataadr = 32'd16; writedata = 32'd104;
    #1;
    n_cmp++; if (count !== 3'd4 || stall !== 1'b1) begin n_bad++; $display("FAIL fill_full: got count=%0d stall=%0b want 4/1", count, stall); end
    tick();
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fill_full_ack_stall: got %0b want 1", stall); end
    if (mem_we && mem_ack) got.push_back(mem_adr);
    tick();
    n_cmp++; if (count !== 3'd3 || stall !== 1'b0) begin n_bad++; $display("FAIL fill_dequeue_only: got count=%0d stall=%0b want 3/0", count, stall); end
    if (mem_we && mem_ack) got.push_back(mem_adr);
    tick();
    memwrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_we && mem_ack) got.push_back(mem_adr);
      tick();
    end
    n_cmp++; if (got.size() != 5) begin n_bad++; $display("FAIL fill_drain_len: got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL fill_order_%0d: got %0d want %0d", i, got[i], want[i]); end
    end
    idle();
  endtask

  task automatic test_forward();
    idle();
    store(32'd80, 32'd5);
    store(32'd84, 32'd7);
    store(32'd80, 32'd9);
    memread = 1'b1; dataadr = 32'd82;
    #1;
    n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin n_bad++; $display("FAIL fwd_youngest: got %0b/%0d want 1/9", ld_hit, ld_data); end
    dataadr = 32'd88;
    #1;
    n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin n_bad++; $display("FAIL fwd_miss: got %0b/%0d want 0/0", ld_hit, ld_data); end
    dataadr = 32'd87;
    #1;
    n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 32'd7) begin n_bad++; $display("FAIL fwd_mid: got %0b/%0d want 1/7", ld_hit, ld_data); end
    memwrite = 1'b1; dataadr = 32'd80;
    #1;
    n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin n_bad++; $display("FAIL fwd_store_wins: got %0b/%0d want 0/0", ld_hit, ld_data); end
    memwrite = 1'b0; memread = 1'b0; mem_ack = 1'b1;
    repeat (2) tick();
    memread = 1'b1; dataadr = 32'd81;
    #1;
    n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin n_bad++; $display("FAIL fwd_dequeuing_entry: got %0b/%0d want 1/9", ld_hit, ld_data); end
    tick();
    n_cmp++; if (ld_hit !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL fwd_after_drain: got hit=%0b empty=%0b want 0/1", ld_hit, empty); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    store(32'd200, 32'd0);
    store(32'd204, 32'd1);
    for (int i = 0; i < 10; i++) begin
      memwrite = 1'b1; mem_ack = 1'b1;
      dataadr = W'(208 + 4 * i); writedata = W'(2 + i);
      #1;
      n_cmp++; if (count !== 3'd2 || mem_wdata !== W'(i)) begin n_bad++; $display("FAIL b2b_%0d: got count=%0d head=%0d want 2/%0d", i, count, mem_wdata, i); end
      tick();
    end
    memwrite = 1'b0; mem_ack = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd2 || mem_wdata !== 32'd10) begin n_bad++; $display("FAIL b2b_end: got count=%0d head=%0d want 2/10", count, mem_wdata); end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    idle();
    store(32'd40, 32'd1);
    store(32'd44, 32'd2);
    store(32'd48, 32'd3);
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL rmid_pre_count: got %0d want 3", count); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || mem_we !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL rmid_async: got count=%0d we=%0b empty=%0b want 0/0/1", count, mem_we, empty); end
    q.delete();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (mem_we !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL rmid_idle_%0d: got we=%0b count=%0d want 0/0", i, mem_we, count); end
      tick();
    end
    idle();
  endtask

  task automatic test_boundary();
    idle();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (mem_we !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL bnd_empty_ack_%0d: got we=%0b count=%0d want 0/0", i, mem_we, count); end
      tick();
    end
    mem_ack = 1'b0;
    store(32'd300, 32'd33);
    #1;
    n_cmp++; if (mem_adr !== 32'd300 || mem_wdata !== 32'd33 || count !== 3'd1) begin n_bad++; $display("FAIL bnd_after_empty_ack: got %0d/%0d count=%0d want 300/33/1", mem_adr, mem_wdata, count); end
    drain();
  endtask

  task automatic test_random();
    bit          e_stall, e_we, e_hit;
    logic [W-1:0] e_data;
    idle();
    for (int c = 0; c < 400; c++) begin
      memwrite  = ($urandom_range(0, 99) < 55);
      memread   = ($urandom_range(0, 1) == 1);
      mem_ack   = ($urandom_range(0, 99) < 45);
      dataadr   = W'({$urandom_range(0, 7), 2'($urandom)});
      writedata = $urandom;
      #1;
      e_stall = memwrite && (q.size() == DEPTH);
      e_we    = (q.size() != 0);
      e_hit   = memread && !memwrite && m_hit(dataadr);
      e_data  = e_hit ? m_data(dataadr) : '0;
      n_cmp++; if (count !== 3'(q.size()) || empty !== (q.size() == 0)) begin n_bad++; $display("FAIL rnd_count_%0d: got %0d/%0b want %0d", c, count, empty, q.size()); end
      n_cmp++; if (stall !== e_stall || mem_we !== e_we) begin n_bad++; $display("FAIL rnd_flow_%0d: got stall=%0b we=%0b want %0b/%0b", c, stall, mem_we, e_stall, e_we); end
      n_cmp++; if (ld_hit !== e_hit || ld_data !== e_data) begin n_bad++; $display("FAIL rnd_fwd_%0d: got %0b/%0h want %0b/%0h", c, ld_hit, ld_data, e_hit, e_data); end
      if (q.size() != 0) begin
        n_cmp++; if (mem_adr !== ent_adr(q[0]) || mem_wdata !== ent_dat(q[0])) begin n_bad++; $display("FAIL rnd_head_%0d: got %0h/%0h want %0h/%0h", c, mem_adr, mem_wdata, ent_adr(q[0]), ent_dat(q[0])); end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_back_to_back();
    test_reset_mid_drain();
    test_boundary();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
